dice_turn_sequencer: RTL
========================

// Module: dice_turn_sequencer
// PURPOSE
//  Game-flow controller for the dice race. Owns both player tile positions and the active-turn flag.
//  Consumes dice results, advances the active player one tile per step and handshakes each step with
//  the game renderer (pos_valid out, turn_done back). Detects the winner and alternates turns.
//  Sits between the dice-recognition path and the UI generator; its outputs drive p1_pos/p2_pos/
//  pos_valid/winner_valid/turn directly.
// PARAMETERS
//  LAST_TILE       15         finish tile index (4-bit tile space, 0..15)
//  TIMEOUT_CYCLES  25_000_000 watchdog limit per step, in clk cycles; used only with DICE_TURN_TIMEOUT_EN
// PORTS
//  clk           in   1  system clock
//  reset         in   1  asynchronous, active-high reset
//  start_game    in   1  1-cycle pulse: (re)start match from intro menu
//  dice_valid    in   1  1-cycle pulse: dice_value is valid
//  dice_value    in   3  pips rolled, legal 1..6
//  turn_done     in   1  1-cycle pulse from renderer: current step animation finished
//  p1_pos        out  4  player 1 tile index
//  p2_pos        out  4  player 2 tile index
//  pos_valid     out  1  1-cycle pulse: a position just changed, renderer starts animating
//  winner_valid  out  1  level: match over, held until start_game or reset
//  turn          out  1  active player (0 = P1, 1 = P2); after a win, identifies the winner
//  busy          out  1  high in STEP/WAIT_ANIM/SWITCH (dice input not accepted)
// BEHAVIOUR
//  - One clock, asynchronous active-high reset: clk, reset.
//  - All outputs are registered. Reset values: p1_pos = p2_pos = 0, pos_valid = 0, winner_valid = 0,
//    turn = 0, busy = 0, state = IDLE, steps_left = 0. Reset mid-operation aborts immediately to these values.
//  - FSM states: IDLE, WAIT_DICE, STEP, WAIT_ANIM, SWITCH, WIN.
//  - IDLE: waits for start_game, then goes to WAIT_DICE.
//  - WAIT_DICE: accepts dice_valid with dice_value in 1..6.
//      steps_left <= dice_value, next state STEP.
//      dice_value 0 or 7 is dropped; the FSM stays in WAIT_DICE.
//  - STEP: on exit, the active player's position is incremented by 1 and pos_valid is set for exactly
//    one cycle, together with the new position. Next state is WAIT_ANIM. First pos_valid is visible
//    2 cycles after the accepted dice_valid.
//  - WAIT_ANIM: waits for turn_done (any cycle, including the pos_valid cycle). On turn_done,
//    steps_left is decremented, then:
//      active pos == LAST_TILE            -> WIN (remaining steps discarded; overshoot clamps)
//      else steps_left (after decrement) == 0 -> SWITCH
//      else                               -> STEP
//  - SWITCH: one cycle; turn toggles; next state WAIT_DICE.
//  - WIN: winner_valid = 1; turn frozen at the winner; positions frozen.
//  - start_game in any state except IDLE restarts the match: positions 0, turn 0, winner_valid 0,
//    steps_left 0, next state WAIT_DICE. This is a synchronous restart.
//  - Simultaneous events:
//      start_game with dice_valid or turn_done -> start_game wins; the other input is dropped.
//      turn_done outside WAIT_ANIM             -> ignored.
//      dice_valid outside WAIT_DICE            -> ignored (not queued).
//  - Arithmetic: positions are 4-bit unsigned; an increment is never issued at LAST_TILE, so no wrap.
//    steps_left is 3-bit.
// CONFIGURATION
//  - DICE_TURN_TIMEOUT_EN defined: a watchdog counter clears on entry to WAIT_ANIM. If it reaches
//    TIMEOUT_CYCLES without turn_done, the FSM behaves exactly as if turn_done had arrived that cycle.
//  - DICE_TURN_TIMEOUT_EN undefined: no counter is built; WAIT_ANIM waits for turn_done indefinitely.
// STRUCTURE
//  - Shared package dice_race_pkg holds:
//      typedef enum logic [2:0] game_state_t (the six states above)
//      localparam TILE_W = 4
//      localparam LAST_TILE_DEF = 15
//      localparam DICE_MIN = 1, DICE_MAX = 6
//  - One sub-module, turn_watchdog (counter + expiry pulse). It is instantiated only under
//    DICE_TURN_TIMEOUT_EN. Everything else is a single FSM plus position/step registers.
// TESTING
//  1. reset, start_game, dice 3 with turn_done 5 cycles after each pos_valid
//     -> p1_pos goes 1, 2, 3 with 3 pos_valid pulses; turn -> 1; back in WAIT_DICE.
//  2. dice_value 0 then 7 in WAIT_DICE
//     -> no pos_valid; state stays WAIT_DICE; positions unchanged.
//  3. p1_pos = 13, P1 rolls 6
//     -> positions 14 and 15 only, then winner_valid = 1, turn = 0; later dice_valid ignored.
//  4. dice_valid during WAIT_ANIM, and start_game in the same cycle as turn_done
//     -> the dice is dropped; the restart wins (positions 0, turn 0, WAIT_DICE).
//  5. reset asserted mid-step (p2_pos = 7, busy = 1)
//     -> all outputs 0 asynchronously; FSM in IDLE; start_game is required to resume.
//  6. DICE_TURN_TIMEOUT_EN with TIMEOUT_CYCLES = 16, no turn_done
//     -> the next step starts 16 cycles after pos_valid. Without the macro, the FSM stays in WAIT_ANIM.

Source files
------------

// File: rtl/dice_race_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dice_race_pkg : shared types and constants for the dice race game flow   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package dice_race_pkg;

  localparam int unsigned TILE_W        = 4;
  localparam int unsigned LAST_TILE_DEF = 15;
  localparam int unsigned DICE_MIN      = 1;
  localparam int unsigned DICE_MAX      = 6;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DICE = 3'd1,
    STEP      = 3'd2,
    WAIT_ANIM = 3'd3,
    SWITCH    = 3'd4,
    WIN       = 3'd5
  } game_state_t;

endpackage
`default_nettype wire

// File: rtl/turn_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | turn_watchdog : per-step animation timeout, expires TIMEOUT_CYCLES after |
// | run rises. Rev 1.0                                                       |
// +--------------------------------------------------------------------------+
module turn_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expire
);

  localparam int unsigned c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_terminal = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] r_count;

  // Count is zero in the first cycle of run, so expiry lands on cycle TIMEOUT_CYCLES-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (!run) begin
      r_count <= '0;
    end else if (r_count != c_terminal) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expire = run && (r_count == c_terminal);

endmodule
`default_nettype wire

// File: rtl/dice_turn_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dice_turn_sequencer : dice race game-flow FSM (positions, turns, winner) |
// | Optional step watchdog: DICE_TURN_TIMEOUT_EN. Rev 1.0                    |
// +--------------------------------------------------------------------------+
module dice_turn_sequencer
  import dice_race_pkg::*;
#(
  parameter int unsigned LAST_TILE      = LAST_TILE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_game,
  input  logic              dice_valid,
  input  logic [2:0]        dice_value,
  input  logic              turn_done,
  output logic [TILE_W-1:0] p1_pos,
  output logic [TILE_W-1:0] p2_pos,
  output logic              pos_valid,
  output logic              winner_valid,
  output logic              turn,
  output logic              busy
);

  localparam logic [TILE_W-1:0] c_last_tile = TILE_W'(LAST_TILE);

  game_state_t       r_state;
  logic [2:0]        r_steps_left;
  logic              w_dice_legal;
  logic              w_step_done;
  logic [TILE_W-1:0] w_active_pos;

  assign w_dice_legal = (dice_value >= 3'(DICE_MIN)) && (dice_value <= 3'(DICE_MAX));
  assign w_active_pos = turn ? p2_pos : p1_pos;

`ifdef DICE_TURN_TIMEOUT_EN
  logic w_wd_expire;

  turn_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_turn_watchdog (
    .clk    (clk),
    .reset  (reset),
    .run    (r_state == WAIT_ANIM),
    .expire (w_wd_expire)
  );

  assign w_step_done = turn_done || w_wd_expire;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_step_done      = turn_done;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_steps_left <= 3'd0;
      p1_pos       <= '0;
      p2_pos       <= '0;
      pos_valid    <= 1'b0;
      winner_valid <= 1'b0;
      turn         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      pos_valid <= 1'b0;
      // Restart takes priority over any dice or animation event in the same cycle.
      if (start_game) begin
        r_state      <= WAIT_DICE;
        r_steps_left <= 3'd0;
        p1_pos       <= '0;
        p2_pos       <= '0;
        winner_valid <= 1'b0;
        turn         <= 1'b0;
        busy         <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
          end
          WAIT_DICE: begin
            if (dice_valid && w_dice_legal) begin
              r_steps_left <= dice_value;
              r_state      <= STEP;
              busy         <= 1'b1;
            end
          end
          STEP: begin
            if (turn) p2_pos <= p2_pos + 1'b1;
            else      p1_pos <= p1_pos + 1'b1;
            pos_valid <= 1'b1;
            r_state   <= WAIT_ANIM;
          end
          WAIT_ANIM: begin
            if (w_step_done) begin
              r_steps_left <= r_steps_left - 3'd1;
              // Reaching the finish ends the turn even with steps remaining.
              if (w_active_pos == c_last_tile) begin
                r_steps_left <= 3'd0;
                r_state      <= WIN;
                winner_valid <= 1'b1;
                busy         <= 1'b0;
              end else if (r_steps_left == 3'd1) begin
                r_state <= SWITCH;
              end else begin
                r_state <= STEP;
              end
            end
          end
          SWITCH: begin
            turn    <= ~turn;
            r_state <= WAIT_DICE;
            busy    <= 1'b0;
          end
          WIN: begin
          end
          default: begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
